syn_updown_cnt: RTL and testbench
=================================

Name: syn_updown_cnt

Overview:
- Parametrised synchronous up/down counter; next generation of the team's T-flip-flop synchronous counter.
- Adds:
  - direction control
  - synchronous parallel load
  - programmable modulus (terminal value)
  - terminal-count and wrap indications
- Used as a general-purpose event/timer counter alongside the existing counters.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2 to 32.
- RST_VAL, 0, value loaded into q on reset; must be at most 2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous, active-low reset. Asserted low: clears state immediately. Deassertion is synchronous to clk externally.
- en  input  1  count enable; q advances only when en=1.
- up  input  1  direction: 1 = count up, 0 = count down; sampled every cycle.
- ld  input  1  synchronous load; takes priority over en.
- d  input  WIDTH  load value.
- mod_max  input  WIDTH  terminal value. The count sequence is 0..mod_max; may change at any time and takes effect the same cycle.
- q  output  WIDTH  registered count.
- tc  output  1  combinational terminal count: the next enabled step hits the boundary.
- wrap  output  1  registered one-cycle pulse; set the cycle after q wrapped.

Behaviour:
- Reset (clr=0, asynchronous): q=RST_VAL, wrap=0; tc follows its equation from the reset q.
- Per rising edge, priority ld > en > hold:
  - ld=1: q<=d regardless of en/up; wrap<=0. d may exceed mod_max (see out-of-range rules).
  - ld=0, en=1, up=1: if q>=mod_max then q<=0 and wrap<=1, else q<=q+1 and wrap<=0.
  - ld=0, en=1, up=0: if q==0 then q<=mod_max and wrap<=1, else q<=q-1 and wrap<=0.
  - ld=0, en=0: q holds; wrap<=0.
- tc = en & ~ld & ((up & (q>=mod_max)) | (~up & (q==0))).
- Latency: q updates one cycle after the qualifying inputs are sampled; wrap asserts in the same cycle as the wrapped q value.
- Arithmetic:
  - All comparisons are unsigned, WIDTH bits.
  - No carry out beyond WIDTH.
  - mod_max=2^WIDTH-1 gives natural binary wrap.
- Boundary and out-of-range cases:
  - mod_max=0: q stays 0 when enabled; wrap pulses every enabled cycle; tc=en&~ld.
  - q>mod_max while counting up (after a load or a mod_max decrease): next enabled edge gives q=0 with a wrap pulse.
  - q>mod_max while counting down: plain decrement until 0 is reached, then reload to mod_max.
  - Direction reversal mid-count takes effect on the next edge with no lost or extra step.
  - ld and en high together: load wins; no wrap.
  - Reset mid-count: q=RST_VAL immediately; the first edge after release counts from RST_VAL.
- Implementation:
  - Each bit is a T cell.
  - The toggle enable for bit i is the AND-chain of the lower bits, built for direction: up uses the ones chain, down uses the zeros chain.
  - The wrap and load muxes sit in front of the register.

Optional Feature:
- Macro: SYN_UPDOWN_CNT_SATURATE_EN.
- Defined:
  - The count saturates instead of wrapping: up with q>=mod_max gives q<=mod_max; down at q==0 holds 0.
  - wrap is never asserted (tied 0); tc is unchanged.
  - ld still overrides.
- Undefined: the wrap-around behaviour above.

Decomposition:
- Shared package syn_cnt_pkg:
  - direction constants CNT_UP=1'b1 and CNT_DN=1'b0
  - function to compute the toggle-chain width from WIDTH
- One natural sub-module, syn_cnt_tcell: a single T flip-flop with asynchronous active-low clr, reset value taken from RST_VAL, plus a synchronous load input (d_i, ld). It is instanced WIDTH times via generate.

Test Plan:
- WIDTH=4, mod_max=15, up=1, en=1 for 17 cycles from reset:
  - q goes 0..15 then 0
  - tc=1 only while q=15
  - wrap=1 exactly in the cycle q returns to 0
- mod_max=9, up=0, ld with d=3, then en=1 for 5 cycles:
  - q goes 3,2,1,0,9,8
  - wrap pulses with q=9
  - tc=1 while q=0
- mod_max=5, ld d=12, up=1, en=1: next q=0 with a wrap pulse; with up=0 instead, q goes 12,11,...
- Simultaneous ld=1, en=1, d=7 at q=5: q=7, no wrap; en=0 for 3 cycles holds 7 and tc=0.
- Assert clr low asynchronously mid-cycle at q=6 (RST_VAL=0):
  - q=0 immediately, before the next clk edge
  - after release, counting resumes from 0
- With SYN_UPDOWN_CNT_SATURATE_EN, mod_max=3, up=1, en=1 for 6 cycles: q goes 0,1,2,3,3,3; wrap stays 0; then up=0 reaches 0 and holds.

Source files
------------

// File: rtl/syn_cnt_pkg.sv
// Shared definitions for the synchronous T-cell counter family:
// direction encoding and toggle-chain sizing.
package syn_cnt_pkg;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  // Chain entry i gates the toggle of bit i; the carry out of the top bit is never used.
  function automatic int unsigned chain_width(input int unsigned width);
    return width;
  endfunction

endpackage

// File: rtl/syn_cnt_tcell.sv
// Single counter bit: T flip-flop with asynchronous active-low clear and a
// synchronous load that takes priority over the toggle.
module syn_cnt_tcell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic t,
  input  logic ld,
  input  logic d_i,
  output logic q
);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q <= RST_BIT;
    end else if (ld) begin
      q <= d_i;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/syn_updown_cnt.sv
// Up/down counter with parallel load, programmable terminal value, tc and wrap.
// Define SYN_UPDOWN_CNT_SATURATE_EN to saturate at the boundaries instead of wrapping.
module syn_updown_cnt
  import syn_cnt_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] mod_max,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam int unsigned      CHAIN_W = chain_width(WIDTH);
  localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RST_VAL);

  logic [CHAIN_W-1:0] chain_up;
  logic [CHAIN_W-1:0] chain_dn;
  logic [WIDTH-1:0]   t;
  logic [WIDTH-1:0]   d_eff;
  logic               at_top;
  logic               at_zero;
  logic               ld_eff;

  // q above mod_max counts as "at top" so an out-of-range value wraps on the next up step.
  assign at_top  = (q >= mod_max);
  assign at_zero = (q == '0);
  assign tc      = en & ~ld & (((up == CNT_UP) & at_top) | ((up == CNT_DN) & at_zero));

  assign chain_up[0] = 1'b1;
  assign chain_dn[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 1; gi < CHAIN_W; gi++) begin : g_chain
      assign chain_up[gi] = chain_up[gi-1] & q[gi-1];
      assign chain_dn[gi] = chain_dn[gi-1] & ~q[gi-1];
    end
  endgenerate

  // A boundary step is carried out as a load, so the toggle chain never has to handle it.
  assign ld_eff = ld | tc;

`ifdef SYN_UPDOWN_CNT_SATURATE_EN
  assign d_eff = ld ? d : ((up == CNT_UP) ? mod_max : '0);
  assign wrap  = 1'b0;
`else
  assign d_eff = ld ? d : ((up == CNT_UP) ? '0 : mod_max);

  logic wrap_reg;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wrap_reg <= 1'b0;
    end else begin
      wrap_reg <= tc;
    end
  end

  assign wrap = wrap_reg;
`endif

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign t[gi] = en & ((up == CNT_UP) ? chain_up[gi] : chain_dn[gi]);

      syn_cnt_tcell #(
        .RST_BIT (RST_Q[gi])
      ) u_tcell (
        .clk (clk),
        .clr (clr),
        .t   (t[gi]),
        .ld  (ld_eff),
        .d_i (d_eff[gi]),
        .q   (q[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_syn_updown_cnt.sv
// Randomised and directed checks of syn_updown_cnt against an arithmetic reference model.
module tb_syn_updown_cnt;

  localparam int W = 4;
`ifdef SYN_UPDOWN_CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         clr;
  logic         en;
  logic         up;
  logic         ld;
  logic [W-1:0] d;
  logic [W-1:0] mod_max;
  logic [W-1:0] q;
  logic         tc;
  logic         wrap;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_q;
  logic         m_wrap;

  always #5 clk = ~clk;

  syn_updown_cnt #(
    .WIDTH   (W),
    .RST_VAL (0)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .en      (en),
    .up      (up),
    .ld      (ld),
    .d       (d),
    .mod_max (mod_max),
    .q       (q),
    .tc      (tc),
    .wrap    (wrap)
  );

  function automatic logic ref_tc();
    return en && !ld && ((up && (m_q >= mod_max)) || (!up && (m_q == 0)));
  endfunction

  // Advance one rising edge and apply the counting rules to the model.
  task automatic tick();
    @(posedge clk);
    if (ld) begin
      m_q    = d;
      m_wrap = 1'b0;
    end else if (en && up) begin
      if (m_q >= mod_max) begin
        m_q    = SAT ? mod_max : '0;
        m_wrap = !SAT;
      end else begin
        m_q    = m_q + 1'b1;
        m_wrap = 1'b0;
      end
    end else if (en) begin
      if (m_q == 0) begin
        m_q    = SAT ? '0 : mod_max;
        m_wrap = !SAT;
      end else begin
        m_q    = m_q - 1'b1;
        m_wrap = 1'b0;
      end
    end else begin
      m_wrap = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b0;
    #3;
    m_q    = '0;
    m_wrap = 1'b0;
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic test_reset();
    en = 1'b0; up = 1'b1; ld = 1'b0; d = '0; mod_max = 4'd15;
    do_reset();
    checks++;
    if (q !== 4'd0) begin errors++; $display("FAIL reset_q: got %0d expected 0", q); end
    checks++;
    if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %0b expected 0", wrap); end
    en = 1'b1; up = 1'b0; #1;
    checks++;
    if (tc !== 1'b1) begin errors++; $display("FAIL reset_tc_down: got %0b expected 1", tc); end
    en = 1'b0; #1;
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc_idle: got %0b expected 0", tc); end
    $display("test_reset: q=%0d wrap=%0b", q, wrap);
  endtask

  task automatic test_count_up();
    do_reset();
    mod_max = 4'd15; up = 1'b1; en = 1'b1; ld = 1'b0; #1;
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (tc !== ref_tc()) begin errors++; $display("FAIL up_tc[%0d]: got %0b expected %0b", i, tc, ref_tc()); end
      tick();
      checks++;
      if (q !== m_q || wrap !== m_wrap) begin
        errors++; $display("FAIL up_q[%0d]: got q=%0d wrap=%0b expected q=%0d wrap=%0b", i, q, wrap, m_q, m_wrap);
      end
    end
    $display("test_count_up: final q=%0d wrap=%0b", q, wrap);
  endtask

  task automatic test_down_load();
    mod_max = 4'd9; up = 1'b0; en = 1'b0; ld = 1'b1; d = 4'd3;
    tick();
    ld = 1'b0; en = 1'b1; #1;
    checks++;
    if (q !== 4'd3) begin errors++; $display("FAIL down_load_q: got %0d expected 3", q); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (tc !== ref_tc()) begin errors++; $display("FAIL down_tc[%0d]: got %0b expected %0b", i, tc, ref_tc()); end
      tick();
      checks++;
      if (q !== m_q || wrap !== m_wrap) begin
        errors++; $display("FAIL down_q[%0d]: got q=%0d wrap=%0b expected q=%0d wrap=%0b", i, q, wrap, m_q, m_wrap);
      end
    end
    $display("test_down_load: final q=%0d wrap=%0b", q, wrap);
  endtask

  task automatic test_out_of_range();
    mod_max = 4'd5; up = 1'b1; en = 1'b0; ld = 1'b1; d = 4'd12;
    tick();
    ld = 1'b0; en = 1'b1;
    tick();
    checks++;
    if (q !== m_q || wrap !== m_wrap) begin
      errors++; $display("FAIL oor_up: got q=%0d wrap=%0b expected q=%0d wrap=%0b", q, wrap, m_q, m_wrap);
    end
    ld = 1'b1; en = 1'b0;
    tick();
    ld = 1'b0; en = 1'b1; up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== m_q || wrap !== m_wrap) begin
        errors++; $display("FAIL oor_down[%0d]: got q=%0d wrap=%0b expected q=%0d wrap=%0b", i, q, wrap, m_q, m_wrap);
      end
    end
    $display("test_out_of_range: final q=%0d", q);
  endtask

  task automatic test_ld_priority();
    mod_max = 4'd15; up = 1'b1; en = 1'b0; ld = 1'b1; d = 4'd5;
    tick();
    en = 1'b1; d = 4'd7; #1;
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL ld_en_tc: got %0b expected 0", tc); end
    tick();
    checks++;
    if (q !== 4'd7 || wrap !== 1'b0) begin
      errors++; $display("FAIL ld_en_q: got q=%0d wrap=%0b expected q=7 wrap=0", q, wrap);
    end
    ld = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== m_q || tc !== 1'b0 || wrap !== 1'b0) begin
        errors++; $display("FAIL hold[%0d]: got q=%0d tc=%0b wrap=%0b expected q=%0d tc=0 wrap=0", i, q, tc, wrap, m_q);
      end
    end
    $display("test_ld_priority: q=%0d", q);
  endtask

  task automatic test_async_reset();
    mod_max = 4'd15; up = 1'b1; en = 1'b0; ld = 1'b1; d = 4'd6;
    tick();
    ld = 1'b0; en = 1'b1;
    #2;
    clr = 1'b0;
    #1;
    m_q = '0; m_wrap = 1'b0;
    checks++;
    if (q !== 4'd0 || wrap !== 1'b0) begin
      errors++; $display("FAIL async_clr: got q=%0d wrap=%0b expected q=0 wrap=0", q, wrap);
    end
    @(negedge clk);
    clr = 1'b1;
    tick();
    checks++;
    if (q !== m_q) begin errors++; $display("FAIL after_clr: got %0d expected %0d", q, m_q); end
    $display("test_async_reset: q=%0d", q);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) != 0);
      up = $urandom_range(0, 1) != 0;
      ld = ($urandom_range(0, 9) == 0);
      d  = W'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       mod_max = 4'd0;
          1:       mod_max = 4'd15;
          default: mod_max = W'($urandom_range(0, 15));
        endcase
      end
      #1;
      checks++;
      if (tc !== ref_tc()) begin errors++; $display("FAIL rnd_tc[%0d]: got %0b expected %0b", i, tc, ref_tc()); end
      if ($urandom_range(0, 99) == 0) begin
        clr = 1'b0; #1;
        m_q = '0; m_wrap = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        #1;
      end
      tick();
      checks++;
      if (q !== m_q || wrap !== m_wrap) begin
        errors++; $display("FAIL rnd_q[%0d]: got q=%0d wrap=%0b expected q=%0d wrap=%0b", i, q, wrap, m_q, m_wrap);
      end
    end
    $display("test_random: 400 cycles, final q=%0d", q);
  endtask

`ifdef SYN_UPDOWN_CNT_SATURATE_EN
  task automatic test_saturate();
    logic [W-1:0] exp_up [6];
    logic [W-1:0] exp_dn [6];
    exp_up = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3};
    exp_dn = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
    ld = 1'b0; en = 1'b0; up = 1'b1; mod_max = 4'd3;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (q !== exp_up[i] || wrap !== 1'b0) begin
        errors++; $display("FAIL sat_up[%0d]: got q=%0d wrap=%0b expected q=%0d wrap=0", i, q, wrap, exp_up[i]);
      end
    end
    up = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (q !== exp_dn[i] || wrap !== 1'b0) begin
        errors++; $display("FAIL sat_dn[%0d]: got q=%0d wrap=%0b expected q=%0d wrap=0", i, q, wrap, exp_dn[i]);
      end
    end
    $display("test_saturate: q=%0d", q);
  endtask
`endif

  initial begin
    test_reset();
    test_count_up();
    test_down_load();
    test_out_of_range();
    test_ld_priority();
    test_async_reset();
    test_random();
`ifdef SYN_UPDOWN_CNT_SATURATE_EN
    test_saturate();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
